// File: rtl/reg_window_fp_ctrl.sv
// Frame-pointer sequencer for a windowed register file: turns CALL/RTN requests
// into a one-cycle FP move strobe, keeps a LIFO of saved FPs, and flags faults.
module reg_window_fp_ctrl #(
  parameter  int FP_W        = 7,
  parameter  int WIN         = 8,
  parameter  int STACK_DEPTH = 8,
  localparam int AW          = $clog2(STACK_DEPTH),
  localparam int DW          = AW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_call_req,
  input  logic            i_rtn_req,
  input  logic [FP_W-1:0] i_call_offset,
  input  logic            i_fault_clr,
  output logic [FP_W-1:0] o_fp,
  output logic [FP_W-1:0] o_new_fp,
  output logic            o_fp_move,
  output logic            o_fp_push_up,
  output logic            o_busy,
  output logic            o_ack,
  output logic            o_fault,
  output logic [1:0]      o_fault_code,
  output logic [DW-1:0]   o_depth
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE, S_FAULT} state_t;

  localparam logic [FP_W:0] LIMIT = (FP_W+1)'(2**FP_W - WIN);

  state_t          r_state, w_next_state;
  logic [FP_W-1:0] r_fp, r_target;
  logic [FP_W-1:0] r_stack [STACK_DEPTH];
  logic [DW-1:0]   r_depth;
  logic            r_push_up;
  logic [1:0]      r_fault_code, w_fault_code_nxt;
  logic            w_do_push, w_do_pop, w_move;
  logic [FP_W:0]   w_sum;
  logic [AW-1:0]   w_top_idx;

  // One extra bit keeps the carry so an overflowing offset is caught, not wrapped.
  assign w_sum     = {1'b0, r_fp} + {1'b0, i_call_offset};
  assign w_top_idx = r_depth[AW-1:0] - AW'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next_state     = r_state;
    w_fault_code_nxt = r_fault_code;
    w_do_push        = 1'b0;
    w_do_pop         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_call_req && i_rtn_req) begin
          w_next_state     = S_FAULT;
          w_fault_code_nxt = 2'd3;
        end else if (i_call_req) begin
          if (i_call_offset == '0 || w_sum > LIMIT) begin
            w_next_state     = S_FAULT;
            w_fault_code_nxt = 2'd1;
          end else if (r_depth >= DW'(STACK_DEPTH)) begin
            w_next_state     = S_FAULT;
            w_fault_code_nxt = 2'd2;
          end else begin
            w_next_state = S_MOVE;
            w_do_push    = 1'b1;
          end
        end else if (i_rtn_req) begin
          if (r_depth == '0) begin
            w_next_state     = S_FAULT;
            w_fault_code_nxt = 2'd2;
          end else begin
            w_next_state = S_MOVE;
            w_do_pop     = 1'b1;
          end
        end
      end
      S_MOVE:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      S_FAULT: begin
        if (i_fault_clr) begin
          w_next_state     = S_IDLE;
          w_fault_code_nxt = 2'd0;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_fp         <= '0;
      r_target     <= '0;
      r_depth      <= '0;
      r_push_up    <= 1'b0;
      r_fault_code <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_next_state;
      r_fault_code <= w_fault_code_nxt;
      if (w_do_push) begin
        r_depth   <= r_depth + DW'(1);
        r_target  <= w_sum[FP_W-1:0];
        r_push_up <= 1'b1;
      end else if (w_do_pop) begin
        r_depth   <= r_depth - DW'(1);
        r_target  <= r_stack[w_top_idx];
        r_push_up <= 1'b0;
      end
      if (r_state == S_MOVE) r_fp <= r_target;
    end
  end

  // NOTE: the saved-FP array has no reset; Depth alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_stack[r_depth[AW-1:0]] <= r_fp;
  end

  assign w_move       = (r_state == S_MOVE);
  assign o_fp         = r_fp;
  assign o_fp_move    = w_move;
  assign o_new_fp     = w_move ? r_target : r_fp;
  assign o_fp_push_up = w_move & r_push_up;
  assign o_busy       = w_move || (r_state == S_DONE);
  assign o_ack        = (r_state == S_DONE);
  assign o_fault      = (r_state == S_FAULT);
  assign o_fault_code = r_fault_code;
  assign o_depth      = r_depth;

endmodule

// File: tb/tb_reg_window_fp_ctrl.sv
// Self-checking bench for reg_window_fp_ctrl: directed vector table, random
// operations against a queue-based FP model, and an async reset mid-MOVE.
module tb_reg_window_fp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       call_req = 1'b0, rtn_req = 1'b0, fault_clr = 1'b0;
  logic [6:0] call_offset = '0;
  logic [6:0] fp, new_fp;
  logic       fp_move, fp_push_up, busy, ack, fault;
  logic [1:0] fault_code;
  logic [3:0] depth;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: current FP and a queue of saved FPs.
  int m_fp = 0;
  int m_stack[$];

  typedef struct {
    bit call;
    bit rtn;
    int off;
    int exp_code;
    int exp_fp;
    int exp_depth;
  } vec_t;
  vec_t vecs[$];

  reg_window_fp_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_call_req(call_req), .i_rtn_req(rtn_req),
    .i_call_offset(call_offset), .i_fault_clr(fault_clr),
    .o_fp(fp), .o_new_fp(new_fp), .o_fp_move(fp_move), .o_fp_push_up(fp_push_up),
    .o_busy(busy), .o_ack(ack), .o_fault(fault), .o_fault_code(fault_code),
    .o_depth(depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit c, bit r, int off, int code, int efp, int edep);
    vec_t v;
    v.call = c; v.rtn = r; v.off = off;
    v.exp_code = code; v.exp_fp = efp; v.exp_depth = edep;
    return v;
  endfunction

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE with requests low.
  task automatic do_op(input bit c, input bit r, input int off, output int code_seen);
    int  exp_code, exp_new;
    exp_code = 0;
    exp_new  = m_fp;
    if (c && r)
      exp_code = 3;
    else if (c) begin
      if (off == 0 || m_fp + off > 120) exp_code = 1;
      else if (m_stack.size() >= 8)     exp_code = 2;
      else begin
        m_stack.push_back(m_fp);
        exp_new = m_fp + off;
      end
    end else begin
      if (m_stack.size() == 0) exp_code = 2;
      else exp_new = m_stack.pop_back();
    end

    check("idle_busy", busy, 0);
    call_req = c; rtn_req = r; call_offset = 7'(off);
    @(negedge clk);
    if (exp_code == 0) begin
      check("move_strobe", fp_move, 1);
      check("move_new_fp", new_fp, exp_new);
      check("move_push_up", fp_push_up, c);
      check("move_busy", busy, 1);
      check("move_fp_old", fp, m_fp);
      @(negedge clk);
      check("done_ack", ack, 1);
      check("done_busy", busy, 1);
      check("done_strobe", fp_move, 0);
      check("done_fp", fp, exp_new);
      check("done_new_fp_eq_fp", new_fp, exp_new);
      code_seen = 0;
      call_req = 0; rtn_req = 0;
      m_fp = exp_new;
      @(negedge clk);
      check("idle_ack_low", ack, 0);
    end else begin
      check("fault_flag", fault, 1);
      check("fault_code", fault_code, exp_code);
      check("fault_no_move", fp_move, 0);
      check("fault_fp", fp, m_fp);
      @(negedge clk);
      check("fault_sticky", fault, 1);
      check("fault_no_ack", ack, 0);
      code_seen = fault_code;
      call_req = 0; rtn_req = 0; fault_clr = 1;
      @(negedge clk);
      fault_clr = 0;
      check("clr_fault", fault, 0);
      check("clr_code", fault_code, 0);
    end
    check("depth", depth, m_stack.size());
  endtask

  initial begin
    int code;
    // Reset state.
    #2;
    check("rst_fp", fp, 0);
    check("rst_new_fp", new_fp, 0);
    check("rst_move", fp_move, 0);
    check("rst_push_up", fp_push_up, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_depth", depth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: nested calls/returns, range, stack and conflict faults.
    vecs.push_back(mk(1, 0, 5,   0, 5,   1));
    vecs.push_back(mk(1, 0, 10,  0, 15,  2));
    vecs.push_back(mk(1, 0, 3,   0, 18,  3));
    vecs.push_back(mk(0, 1, 0,   0, 15,  2));
    vecs.push_back(mk(0, 1, 0,   0, 5,   1));
    vecs.push_back(mk(0, 1, 0,   0, 0,   0));
    vecs.push_back(mk(0, 1, 0,   2, 0,   0));
    vecs.push_back(mk(1, 1, 4,   3, 0,   0));
    vecs.push_back(mk(1, 0, 0,   1, 0,   0));
    vecs.push_back(mk(1, 0, 115, 0, 115, 1));
    vecs.push_back(mk(1, 0, 6,   1, 115, 1));
    vecs.push_back(mk(1, 0, 5,   0, 120, 2));
    vecs.push_back(mk(1, 0, 1,   1, 120, 2));
    vecs.push_back(mk(0, 1, 0,   0, 115, 1));
    vecs.push_back(mk(0, 1, 0,   0, 0,   0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 1, 0, i, i));
    vecs.push_back(mk(1, 0, 1,   2, 8,   8));
    vecs.push_back(mk(1, 1, 1,   3, 8,   8));

    foreach (vecs[i]) begin
      do_op(vecs[i].call, vecs[i].rtn, vecs[i].off, code);
      check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
      check($sformatf("vec%0d_fp", i), fp, vecs[i].exp_fp);
      check($sformatf("vec%0d_depth", i), depth, vecs[i].exp_depth);
    end

    // Random operations against the model.
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      do_op(1, 0, $urandom_range(0, 24), code);
      else if (sel < 9) do_op(0, 1, 0, code);
      else              do_op(1, 1, $urandom_range(0, 24), code);
      check("rand_fp", fp, m_fp);
    end

    // Asynchronous reset while FP_move is high.
    rst_n = 1'b0;
    m_fp = 0;
    m_stack.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 0, 4, code);
    call_req = 1; call_offset = 7'd5;
    @(negedge clk);
    check("pre_rst_move", fp_move, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_move", fp_move, 0);
    check("arst_busy", busy, 0);
    check("arst_fp", fp, 0);
    check("arst_depth", depth, 0);
    check("arst_push_up", fp_push_up, 0);
    call_req = 0;
    m_fp = 0;
    m_stack.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 0, 7, code);
    check("post_rst_fp", fp, 7);
    check("post_rst_depth", depth, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_window_fp_ctrl.md
Name: reg_window_fp_ctrl

Overview:
- Frame-pointer sequencer for the 128-entry windowed register file; owns FP and a hardware stack of saved FPs.
- Turns CALL/RTN requests from decode into the register file's one-cycle FP_move / FP_push_up / New_FP control pulse.
- Range-checks every window move and reports faults instead of corrupting the file.
- Sits between decode/control and the register file; decode stalls on Busy.

Parameters:
- FP_W, 7, frame-pointer / register-address width (file depth 2^FP_W = 128).
- WIN, 8, window size in registers.
- STACK_DEPTH, 8, number of saved FPs (power of two).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Call_Req  in  1  level request: move window up by Call_Offset; held until Ack or Fault.
- Rtn_Req  in  1  level request: restore previous FP; held until Ack or Fault.
- Call_Offset  in  FP_W  unsigned window displacement I for CALL.
- Fault_Clr  in  1  clears a sticky fault; FSM returns to IDLE.
- FP  out  FP_W  current frame pointer, the register file window base.
- New_FP  out  FP_W  target FP; valid only while FP_move=1, otherwise equals FP.
- FP_move  out  1  one-cycle window-change strobe to the register file.
- FP_push_up  out  1  1 = CALL (window moves up), 0 = RTN; valid with FP_move, otherwise 0.
- Busy  out  1  high in MOVE and DONE.
- Ack  out  1  one-cycle completion pulse.
- Fault  out  1  sticky error flag.
- Fault_Code  out  2  1 = range, 2 = stack overflow/underflow, 3 = Call+Rtn conflict.
- Depth  out  log2(STACK_DEPTH)+1  saved-FP count.

Behaviour:
- Reset (async, Reset_n=0): FSM=IDLE, FP=0, Depth=0, stack contents don't-care. All outputs 0; New_FP equals FP, which is 0.
- Reset asserted in any state clears immediately, including mid-MOVE. FP_move drops without waiting for a clock. No partial FP update survives.
- States: IDLE, MOVE, DONE, FAULT. Requests are sampled only in IDLE.
- IDLE with Call_Req=1, Rtn_Req=0: compute sum = FP + Call_Offset in FP_W+1 bits.
  - Legal when Call_Offset != 0, sum <= 2^FP_W - WIN (120), and Depth < STACK_DEPTH.
  - Legal: push FP, Depth+1, latch target = sum[FP_W-1:0], go to MOVE with push_up=1.
  - Call_Offset = 0 or sum > 120: go to FAULT with code 1. Range check takes precedence over the stack-full check.
  - Stack full: go to FAULT with code 2.
- IDLE with Rtn_Req=1, Call_Req=0:
  - Depth > 0: pop into target, Depth-1, go to MOVE with push_up=0.
  - Depth = 0: go to FAULT with code 2.
- IDLE with both requests: go to FAULT with code 3. No stack or FP change.
- MOVE, exactly 1 cycle:
  - FP_move=1, New_FP=target, FP_push_up=latched direction, Busy=1.
  - On the closing edge, FP <= target. The register file refills its window during this same edge.
- DONE, 1 cycle: Ack=1, Busy=1, then go to IDLE. Requesters must deassert on Ack. A request still high in IDLE is taken as a new operation.
- FAULT:
  - Fault=1 and Fault_Code held. Ack stays 0, FP and stack are unchanged, requests are ignored.
  - Fault_Clr=1 at an edge: go to IDLE with Fault=0 and Fault_Code=0.
- Throughput: one operation per 3 cycles (IDLE, MOVE, DONE).
- Stack is a LIFO with push/pop index wrap modulo STACK_DEPTH. Depth saturation is guarded by the checks above, so the index never wraps in normal use.
- All arithmetic is unsigned; no modular wrap of FP is ever exposed.

Test Plan:
- Reset, then Call_Req with Call_Offset=5 from FP=0 -> next cycle FP_move=1, New_FP=5, FP_push_up=1; FP=5 after the MOVE edge; Ack in DONE; Depth=1.
- Nested calls with offsets 5, 10, 3, then 3x Rtn_Req -> New_FP sequence 5, 15, 18, then 15, 5, 0 with FP_push_up=0 on each RTN; Depth returns to 0.
- FP=115 and Call_Offset=6 (sum 121) -> Fault=1, Fault_Code=1, FP stays 115, no FP_move. Then Fault_Clr -> IDLE; a Call_Offset=5 call succeeds with FP=120.
- Rtn_Req with Depth=0 -> Fault_Code=2. Nine calls of offset 1 with STACK_DEPTH=8 -> the ninth faults with code 2 and FP=8.
- Call_Req and Rtn_Req asserted together -> Fault_Code=3, Depth and FP unchanged.
- Reset_n pulled low mid-cycle while FP_move=1 -> FP_move, Busy and FP go to 0 asynchronously; after release, a new call works normally.
